// File: rtl/ibex_pkg.sv
// Shared writeback-stage types: instruction class and writeback FSM encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ibex_pkg;

  // Class of the instruction handed from EX to WB.
  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  // Writeback entry state: empty, ALU-style result ready, or waiting on the LSU.
  typedef enum logic [1:0] {
    WB_IDLE     = 2'b00,
    WB_DONE     = 2'b01,
    WB_WAIT_LSU = 2'b10
  } wb_state_e;

endpackage

// File: rtl/ibex_wb_stage.sv
// Writeback stage: single-entry holding register between EX and the register file.
// Latency: OTHER retires 1 cycle after transfer; LOAD/STORE retire in the LSU response cycle (>= 1 cycle).
// Backpressure: ready_wb_o drops only while a load/store waits for its LSU response.
//
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   en_wb_i / ready_wb_o                 EX->WB valid/ready handshake
//   instr_type_wb_i, rf_waddr_id_i,
//   rf_wdata_id_i, rf_we_id_i, pc_id_i   entry payload captured on transfer
//   lsu_resp_valid_i, lsu_resp_err_i,
//   rf_wdata_lsu_i                       LSU response for the held load/store
//   rf_waddr_wb_o, rf_wdata_wb_o,
//   rf_we_wb_o                           register-file write port
//   rf_wdata_fwd_wb_o, rf_write_wb_o     forwarding value / pending-write flag
//   outstanding_load_wb_o                load held awaiting response
//   instr_done_wb_o, pc_wb_o,
//   lsu_err_wb_o                         retire pulse, retiring PC, LSU error pulse
module ibex_wb_stage #(
  parameter bit WbFwdEn    = 1'b1,
  parameter bit SuppressX0 = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        en_wb_i,
  output logic        ready_wb_o,
  input  logic [1:0]  instr_type_wb_i,
  input  logic [4:0]  rf_waddr_id_i,
  input  logic [31:0] rf_wdata_id_i,
  input  logic        rf_we_id_i,
  input  logic [31:0] pc_id_i,

  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,
  input  logic [31:0] rf_wdata_lsu_i,

  output logic [4:0]  rf_waddr_wb_o,
  output logic [31:0] rf_wdata_wb_o,
  output logic        rf_we_wb_o,

  output logic [31:0] rf_wdata_fwd_wb_o,
  output logic        rf_write_wb_o,

  output logic        outstanding_load_wb_o,

  output logic        instr_done_wb_o,
  output logic [31:0] pc_wb_o,
  output logic        lsu_err_wb_o
);

  import ibex_pkg::*;

  wb_state_e      state_q, state_d;
  wb_instr_type_e type_q;
  logic [4:0]     waddr_q;
  logic [31:0]    wdata_q;
  logic           we_q;
  logic [31:0]    pc_q;

  logic in_done, in_wait, lsu_done, xfer, addr_ok, is_load_q;

  assign in_done   = (state_q == WB_DONE);
  assign in_wait   = (state_q == WB_WAIT_LSU);
  assign is_load_q = (type_q == WB_INSTR_LOAD);

  // LSU responses only matter while a load/store is actually held.
  assign lsu_done  = in_wait & lsu_resp_valid_i;

  // A retiring entry frees the slot in the same cycle, so a new
  // instruction can be accepted with no bubble.
  assign ready_wb_o = ~in_wait | lsu_resp_valid_i;
  assign xfer       = en_wb_i & ready_wb_o;

  // Writes to x0 are architecturally discarded when suppression is on.
  assign addr_ok    = ~SuppressX0 | (waddr_q != 5'd0);

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = (wb_instr_type_e'(instr_type_wb_i) == WB_INSTR_OTHER) ? WB_DONE : WB_WAIT_LSU;
    end else if (in_done || lsu_done) begin
      state_d = WB_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WB_IDLE;
      type_q  <= WB_INSTR_LOAD;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        type_q  <= wb_instr_type_e'(instr_type_wb_i);
        waddr_q <= rf_waddr_id_i;
        wdata_q <= rf_wdata_id_i;
        we_q    <= rf_we_id_i;
        pc_q    <= pc_id_i;
      end
    end
  end

  // Register-file write path: purely combinational from state, entry and LSU response.
  assign instr_done_wb_o = in_done | lsu_done;
  assign lsu_err_wb_o    = lsu_done & lsu_resp_err_i;
  assign rf_we_wb_o      = addr_ok & we_q &
                           (in_done | (lsu_done & ~lsu_resp_err_i & is_load_q));
  assign rf_wdata_wb_o   = (in_wait & is_load_q) ? rf_wdata_lsu_i : wdata_q;
  assign rf_waddr_wb_o   = waddr_q;
  assign pc_wb_o         = pc_q;

  assign outstanding_load_wb_o = in_wait & is_load_q;

  // Forwarding view: the pending write is advertised for any occupied entry,
  // but the value is only meaningful once the result is already in hand (WB_DONE).
  assign rf_write_wb_o     = WbFwdEn ? ((state_q != WB_IDLE) & we_q & addr_ok) : 1'b0;
  assign rf_wdata_fwd_wb_o = WbFwdEn ? wdata_q : 32'd0;

endmodule

// File: tb/tb_ibex_wb_stage.sv
// Bench for ibex_wb_stage: directed vectors, entry-occupancy reference model, per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_ibex_wb_stage;

  localparam logic [1:0] T_LOAD  = 2'b00;
  localparam logic [1:0] T_STORE = 2'b01;
  localparam logic [1:0] T_OTHER = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_wb = 1'b0;
  logic        ready_wb;
  logic [1:0]  instr_type = T_OTHER;
  logic [4:0]  waddr_in = '0;
  logic [31:0] wdata_in = '0;
  logic        we_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic        lsu_rv = 1'b0;
  logic        lsu_err = 1'b0;
  logic [31:0] lsu_data = '0;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic [31:0] rf_fwd;
  logic        rf_write;
  logic        outst;
  logic        done;
  logic [31:0] pc_wb;
  logic        err_wb;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  ibex_wb_stage dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .en_wb_i               (en_wb),
    .ready_wb_o            (ready_wb),
    .instr_type_wb_i       (instr_type),
    .rf_waddr_id_i         (waddr_in),
    .rf_wdata_id_i         (wdata_in),
    .rf_we_id_i            (we_in),
    .pc_id_i               (pc_in),
    .lsu_resp_valid_i      (lsu_rv),
    .lsu_resp_err_i        (lsu_err),
    .rf_wdata_lsu_i        (lsu_data),
    .rf_waddr_wb_o         (rf_waddr),
    .rf_wdata_wb_o         (rf_wdata),
    .rf_we_wb_o            (rf_we),
    .rf_wdata_fwd_wb_o     (rf_fwd),
    .rf_write_wb_o         (rf_write),
    .outstanding_load_wb_o (outst),
    .instr_done_wb_o       (done),
    .pc_wb_o               (pc_wb),
    .lsu_err_wb_o          (err_wb)
  );

  always #5 clk = ~clk;

  // Reference model: one held instruction (or none) and its payload.
  logic        m_occ  = 1'b0;
  logic [1:0]  m_kind = '0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_we   = 1'b0;
  logic [31:0] m_pc   = '0;

  typedef struct packed {
    logic        ready;
    logic        done;
    logic        err;
    logic        we;
    logic        write;
    logic        outst;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] fwd;
    logic [31:0] pc;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    logic is_mem, is_load, real_dst, finishing;
    is_mem   = (m_kind != T_OTHER);
    is_load  = (m_kind == T_LOAD);
    real_dst = m_we && (m_addr != 5'd0);
    // An ALU result finishes as soon as it is held; memory ops finish on the response.
    finishing = m_occ && (!is_mem || lsu_rv);
    e.ready = !m_occ || !is_mem || lsu_rv;
    e.done  = finishing;
    e.err   = m_occ && is_mem && lsu_rv && lsu_err;
    e.we    = finishing && real_dst && (!is_mem || (is_load && !lsu_err));
    e.write = m_occ && real_dst;
    e.outst = m_occ && is_load;
    e.waddr = m_addr;
    e.wdata = (m_occ && is_load) ? lsu_data : m_data;
    e.fwd   = m_data;
    e.pc    = m_pc;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_occ  <= 1'b0;
      m_kind <= '0;
      m_addr <= '0;
      m_data <= '0;
      m_we   <= 1'b0;
      m_pc   <= '0;
    end else begin
      if (en_wb && model_out().ready) begin
        m_occ  <= 1'b1;
        m_kind <= instr_type;
        m_addr <= waddr_in;
        m_data <= wdata_in;
        m_we   <= we_in;
        m_pc   <= pc_in;
      end else if (model_out().done) begin
        m_occ <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      e = model_out();
      chk("ready",  {31'd0, ready_wb}, {31'd0, e.ready});
      chk("done",   {31'd0, done},     {31'd0, e.done});
      chk("err",    {31'd0, err_wb},   {31'd0, e.err});
      chk("rf_we",  {31'd0, rf_we},    {31'd0, e.we});
      chk("write",  {31'd0, rf_write}, {31'd0, e.write});
      chk("outst",  {31'd0, outst},    {31'd0, e.outst});
      chk("waddr",  {27'd0, rf_waddr}, {27'd0, e.waddr});
      chk("pc",     pc_wb,             e.pc);
      chk("fwd",    rf_fwd,            e.fwd);
      if (e.we) chk("wdata", rf_wdata, e.wdata);
    end
  end

  // One cycle: drive just after the rising edge, return just after the falling edge.
  task automatic step(input logic en, input logic [1:0] typ, input logic [4:0] a,
                      input logic [31:0] d, input logic w, input logic [31:0] pc,
                      input logic rv, input logic er, input logic [31:0] ld);
    @(posedge clk);
    #1;
    en_wb = en; instr_type = typ; waddr_in = a; wdata_in = d; we_in = w; pc_in = pc;
    lsu_rv = rv; lsu_err = er; lsu_data = ld;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic rv, input logic er, input logic [31:0] ld);
    step(1'b0, T_OTHER, 5'd0, 32'd0, 1'b0, 32'd0, rv, er, ld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t expected below 200000", $time);
    $fatal(1);
  end

  initial begin
    int retires;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    // Reset state: everything 0 except ready.
    chk("rst_ready", {31'd0, ready_wb}, 32'd1);
    chk("rst_outs",  {26'd0, done, err_wb, rf_we, rf_write, outst, |rf_wdata}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU op to x5.
    step(1'b1, T_OTHER, 5'd5, 32'hDEADBEEF, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
    idle(1'b0, 1'b0, 32'd0);
    chk("alu_we",    {31'd0, rf_we}, 32'd1);
    chk("alu_addr",  {27'd0, rf_waddr}, 32'd5);
    chk("alu_data",  rf_wdata, 32'hDEADBEEF);
    chk("alu_done",  {31'd0, done}, 32'd1);
    chk("alu_pc",    pc_wb, 32'h100);

    // Stray LSU response while idle is ignored.
    idle(1'b1, 1'b0, 32'hFFFF0000);
    chk("stray_done", {31'd0, done}, 32'd0);

    // Load to x7, response on the third cycle after transfer.
    step(1'b1, T_LOAD, 5'd7, 32'h0, 1'b1, 32'h104, 1'b0, 1'b0, 32'd0);
    idle(1'b0, 1'b0, 32'd0);
    chk("ld_stall1", {31'd0, ready_wb}, 32'd0);
    chk("ld_outst",  {31'd0, outst}, 32'd1);
    idle(1'b0, 1'b0, 32'd0);
    chk("ld_stall2", {31'd0, ready_wb}, 32'd0);
    idle(1'b1, 1'b0, 32'h12345678);
    chk("ld_we",     {31'd0, rf_we}, 32'd1);
    chk("ld_data",   rf_wdata, 32'h12345678);
    chk("ld_addr",   {27'd0, rf_waddr}, 32'd7);
    chk("ld_ready",  {31'd0, ready_wb}, 32'd1);
    idle(1'b0, 1'b0, 32'd0);
    chk("ld_outst_fall", {31'd0, outst}, 32'd0);

    // Store with error response.
    step(1'b1, T_STORE, 5'd3, 32'h55, 1'b0, 32'h108, 1'b0, 1'b0, 32'd0);
    idle(1'b1, 1'b1, 32'd0);
    chk("st_err",  {31'd0, err_wb}, 32'd1);
    chk("st_done", {31'd0, done}, 32'd1);
    chk("st_we",   {31'd0, rf_we}, 32'd0);

    // Back-to-back ALU ops.
    retires = 0;
    for (int i = 0; i <= 10; i++) begin
      step(i < 10, T_OTHER, 5'(i + 1), 32'hA000 + i, 1'b1, 32'h200 + 4 * i, 1'b0, 1'b0, 32'd0);
      chk("b2b_ready", {31'd0, ready_wb}, 32'd1);
      if (i > 0) retires += int'(done);
    end
    chk("b2b_retires", retires, 32'd10);

    // ALU op to x0 is retired but never written.
    step(1'b1, T_OTHER, 5'd0, 32'hCAFE, 1'b1, 32'h300, 1'b0, 1'b0, 32'd0);
    idle(1'b0, 1'b0, 32'd0);
    chk("x0_we",    {31'd0, rf_we}, 32'd0);
    chk("x0_write", {31'd0, rf_write}, 32'd0);
    chk("x0_done",  {31'd0, done}, 32'd1);

    // Load retiring while the next load is accepted, then error on a load.
    step(1'b1, T_LOAD, 5'd10, 32'h0, 1'b1, 32'h400, 1'b0, 1'b0, 32'd0);
    step(1'b1, T_LOAD, 5'd11, 32'h0, 1'b1, 32'h404, 1'b1, 1'b0, 32'h0BADF00D);
    chk("nb_data", rf_wdata, 32'h0BADF00D);
    idle(1'b1, 1'b1, 32'h11111111);
    chk("ldErr_we",   {31'd0, rf_we}, 32'd0);
    chk("ldErr_addr", {27'd0, rf_waddr}, 32'd11);

    // Reset while a load waits, then a late response.
    step(1'b1, T_LOAD, 5'd9, 32'h0, 1'b1, 32'h500, 1'b0, 1'b0, 32'd0);
    idle(1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready_wb}, 32'd1);
    chk("mid_rst_outst", {31'd0, outst}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b1, 1'b0, 32'h77777777);
    chk("late_done",  {31'd0, done}, 32'd0);
    chk("late_we",    {31'd0, rf_we}, 32'd0);
    chk("late_ready", {31'd0, ready_wb}, 32'd1);
    chk("late_pc",    pc_wb, 32'd0);
    idle(1'b0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_wb_stage.md
IBEX_WB_STAGE -- requirements
Module: ibex_wb_stage

Interface
REQ-001 Parameter WbFwdEn, default 1: when 1, the forwarding outputs are driven; when 0, they are tied to 0.
REQ-002 Parameter SuppressX0, default 1: when 1, register-file writes to address 0 are masked.
REQ-003 clk_i  in  1  sole clock.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 en_wb_i  in  1  EX presents a completed instruction (valid).
REQ-006 ready_wb_o  out  1  WB accepts this cycle; transfer occurs when en_wb_i & ready_wb_o.
REQ-007 instr_type_wb_i  in  2  wb_instr_type_e: WB_INSTR_OTHER, WB_INSTR_LOAD, WB_INSTR_STORE.
REQ-008 rf_waddr_id_i  in  5  destination register.
REQ-009 rf_wdata_id_i  in  32  EX result (result_ex).
REQ-010 rf_we_id_i  in  1  instruction writes the register file.
REQ-011 pc_id_i  in  32  instruction PC.
REQ-012 lsu_resp_valid_i  in  1  LSU response for the held load/store.
REQ-013 lsu_resp_err_i  in  1  LSU response is an error (qualified by lsu_resp_valid_i).
REQ-014 rf_wdata_lsu_i  in  32  load data.
REQ-015 rf_waddr_wb_o / rf_wdata_wb_o / rf_we_wb_o  out  5/32/1  register-file write port.
REQ-016 rf_wdata_fwd_wb_o / rf_write_wb_o  out  32/1  forwarding value and "WB will write rf_waddr_wb_o".
REQ-017 outstanding_load_wb_o  out  1  load held awaiting response.
REQ-018 instr_done_wb_o / pc_wb_o / lsu_err_wb_o  out  1/32/1  retire pulse, retiring PC, error pulse.

Function
REQ-019 The module SHALL hold a single entry {type, waddr, wdata, we, pc}, captured on the clock edge of a transfer.
REQ-020 The state machine SHALL have three states: WB_IDLE (empty), WB_DONE (OTHER entry), and WB_WAIT_LSU (LOAD or STORE entry).
REQ-021 On a transfer, next state SHALL be WB_DONE for OTHER and WB_WAIT_LSU otherwise; with no transfer, WB_DONE SHALL go to WB_IDLE and WB_WAIT_LSU SHALL hold until lsu_resp_valid_i.
REQ-022 ready_wb_o SHALL be 1 in WB_IDLE, 1 in WB_DONE, 1 in WB_WAIT_LSU only when lsu_resp_valid_i=1, and 0 otherwise.
REQ-023 In WB_DONE, instr_done_wb_o SHALL be 1, rf_we_wb_o SHALL equal we_q, and rf_wdata_wb_o SHALL equal wdata_q.
REQ-024 In WB_WAIT_LSU with lsu_resp_valid_i=1 and no error:
  - instr_done_wb_o SHALL be 1;
  - for a load, rf_we_wb_o SHALL equal we_q and rf_wdata_wb_o SHALL equal rf_wdata_lsu_i;
  - for a store, rf_we_wb_o SHALL be 0.
REQ-025 In WB_WAIT_LSU with lsu_resp_valid_i=1 and lsu_resp_err_i=1, instr_done_wb_o=1, lsu_err_wb_o=1 and rf_we_wb_o=0 SHALL all hold in that cycle.
REQ-026 Completion and a new transfer in the same cycle SHALL retire the old entry and capture the new one, with no bubble.
REQ-027 lsu_resp_valid_i in WB_IDLE or WB_DONE SHALL be ignored and SHALL change no state.
REQ-028 With SuppressX0=1, rf_we_wb_o and rf_write_wb_o SHALL be 0 whenever waddr_q equals 0.
REQ-029 rf_write_wb_o SHALL equal (state≠WB_IDLE) & we_q.
REQ-030 rf_wdata_fwd_wb_o SHALL equal wdata_q; it is valid only in WB_DONE.
REQ-031 outstanding_load_wb_o SHALL be 1 in WB_WAIT_LSU with a LOAD entry and 0 in every other case.
REQ-032 pc_wb_o SHALL equal pc_q; rf_waddr_wb_o SHALL equal waddr_q.
REQ-033 Writeback latency SHALL be: OTHER retires exactly 1 cycle after transfer; LOAD/STORE retire in the lsu_resp_valid_i cycle, minimum 1 cycle after transfer.

Reset
REQ-034 On rst_ni=0, asynchronously: state SHALL be WB_IDLE and the entry registers SHALL be 0.
REQ-035 During and after reset, every output SHALL be 0 except ready_wb_o, which SHALL be 1.
REQ-036 Reset asserted mid-WAIT_LSU SHALL discard the entry, and a subsequent LSU response SHALL be ignored.

Structure
REQ-037 wb_instr_type_e and wb_state_e SHALL reside in ibex_pkg.
REQ-038 The block SHALL be a single module with no sub-module.
REQ-039 The register-file write path SHALL be purely combinational from state, entry and LSU inputs.

Verification
REQ-040 ALU op, waddr=5, wdata=0xDEADBEEF, we=1 → the next cycle shows rf_we_wb_o=1, addr 5, data 0xDEADBEEF, instr_done_wb_o=1.
REQ-041 Load to x7, response after 3 cycles with 0x12345678 → ready_wb_o=0 for 2 cycles, then write of 0x12345678 to x7 and outstanding_load_wb_o falls.
REQ-042 Store followed by an error response → lsu_err_wb_o=1, instr_done_wb_o=1, rf_we_wb_o=0.
REQ-043 Back-to-back ALU ops every cycle for 10 cycles → 10 retire pulses and ready_wb_o continuously 1.
REQ-044 ALU op to x0 with we=1 → rf_we_wb_o=0 and rf_write_wb_o=0, while instr_done_wb_o=1.
REQ-045 Reset asserted during WAIT_LSU, then lsu_resp_valid_i=1 → no write, no retire, and state WB_IDLE.
